// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: host-side first-word-fall-through byte stream.
//   dout       : head-of-queue byte (8'h00 when nothing is queued)
//   dout_valid : dout holds a valid byte
//   dout_ready : consumer accepts dout this cycle
// Modports: master = FIFO (drives data/valid), slave = consumer (drives ready).
interface uart_rx_fifo_if;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte queue behind the 8-bit UART receiver, on the 16x rx clock.
// Captures one byte per rising edge of rx_done and presents bytes to the host
// through a first-word-fall-through stream. Tracks overflow and framing errors.
// Ports:
//   clk, rst_n            : rx clock, synchronous active-low reset
//   rx_done/rx_err/rx_data: receiver outputs
//   host                  : dout/dout_valid/dout_ready stream (master side)
//   count, empty, full    : occupancy status
//   overflow              : sticky drop flag, cleared by clear_overflow
//   frame_err             : one-clk pulse per rising edge of rx_err
// Optional (UART_RX_FIFO_ERR_COUNT_EN): err_count saturating frame_err counter,
//   clear_err_count zeroes it.
module uart_rx_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_done,
  input  logic                  rx_err,
  input  logic [7:0]            rx_data,
  uart_rx_fifo_if.master        host,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  input  logic                  clear_overflow,
  output logic                  frame_err
`ifdef UART_RX_FIFO_ERR_COUNT_EN
  ,
  output logic [7:0]            err_count,
  input  logic                  clear_err_count
`endif
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned DW = 8;

  logic [DW-1:0]         mem_q [DEPTH];
  logic [DW-1:0]         mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  overflow_q, overflow_d;
  logic                  frame_err_q, frame_err_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  push_c, pop_c, wr_en_c;
`ifdef UART_RX_FIFO_ERR_COUNT_EN
  logic [7:0]            err_count_q, err_count_d;
`endif

  // Next-state logic for queue, status and error tracking
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    done_d      = rx_done;
    err_d       = rx_err;
    frame_err_d = rx_err & ~err_q;

    push_c  = rx_done & ~done_q;
    pop_c   = ~empty_q & host.dout_ready;
    // When full, a simultaneous pop frees the head slot the new byte lands in
    wr_en_c = push_c & (~full_q | pop_c);

    if (wr_en_c) begin
      mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end

    case ({wr_en_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == CW'(0));
    full_d  = (count_d == CW'(DEPTH));

    // Set wins over clear
    if (push_c & full_q & ~pop_c) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end

`ifdef UART_RX_FIFO_ERR_COUNT_EN
    err_count_d = err_count_q;
    if (clear_err_count) begin
      err_count_d = frame_err_d ? 8'd1 : 8'd0;
    end else if (frame_err_d && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end
`endif
  end

  // Control/status registers; edge history resets high so levels already
  // asserted at reset release are not taken as new events
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b1;
      err_q       <= 1'b1;
`ifdef UART_RX_FIFO_ERR_COUNT_EN
      err_count_q <= 8'd0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef UART_RX_FIFO_ERR_COUNT_EN
      err_count_q <= err_count_d;
`endif
    end
  end

  // Storage array; contents are don't-care while not covered by count
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign host.dout       = empty_q ? 8'h00 : mem_q[rd_ptr_q];
  assign host.dout_valid = ~empty_q;
  assign count           = count_q;
  assign empty           = empty_q;
  assign full            = full_q;
  assign overflow        = overflow_q;
  assign frame_err       = frame_err_q;
`ifdef UART_RX_FIFO_ERR_COUNT_EN
  assign err_count       = err_count_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_done;
  logic       rx_err;
  logic [7:0] rx_data;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       clear_overflow;
  logic       frame_err;
`ifdef UART_RX_FIFO_ERR_COUNT_EN
  logic [7:0] err_count;
  logic       clear_err_count;
`endif

  int checks = 0;
  int errors = 0;

  uart_rx_fifo_if host_if ();

  uart_rx_fifo #(.DEPTH(16), .ADDR_WIDTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_done        (rx_done),
    .rx_err         (rx_err),
    .rx_data        (rx_data),
    .host           (host_if),
    .count          (count),
    .empty          (empty),
    .full           (full),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .frame_err      (frame_err)
`ifdef UART_RX_FIFO_ERR_COUNT_EN
    ,
    .err_count      (err_count),
    .clear_err_count(clear_err_count)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input int len);
    rx_done = 1'b1;
    rx_data = d;
    repeat (len) tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_done = 1'b0;
    rx_err = 1'b0;
    rx_data = 8'h00;
    clear_overflow = 1'b0;
    host_if.dout_ready = 1'b0;
`ifdef UART_RX_FIFO_ERR_COUNT_EN
    clear_err_count = 1'b0;
`endif
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (host_if.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", host_if.dout); end
    checks++; if (host_if.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", host_if.dout_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
`ifdef UART_RX_FIFO_ERR_COUNT_EN
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
`endif
  endtask

  task automatic test_basic();
    // First pulse: dout_valid must be high right after the push edge
    rx_done = 1'b1;
    rx_data = 8'hA5;
    tick();
    checks++; if (host_if.dout_valid !== 1'b1) begin errors++; $display("FAIL basic_latency_valid: got %b expected 1", host_if.dout_valid); end
    checks++; if (host_if.dout !== 8'hA5) begin errors++; $display("FAIL basic_latency_dout: got %h expected a5", host_if.dout); end
    repeat (15) tick();
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL basic_one_push_per_pulse: got %0d expected 1", count); end
    rx_done = 1'b0;
    tick();
    send_byte(8'h3C, 16);
    send_byte(8'hFF, 16);
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL basic_count3: got %0d expected 3", count); end
    checks++; if (host_if.dout !== 8'hA5) begin errors++; $display("FAIL basic_head: got %h expected a5", host_if.dout); end
    host_if.dout_ready = 1'b1;
    checks++; if (host_if.dout !== 8'hA5) begin errors++; $display("FAIL basic_pop0: got %h expected a5", host_if.dout); end
    tick();
    checks++; if (host_if.dout !== 8'h3C) begin errors++; $display("FAIL basic_pop1: got %h expected 3c", host_if.dout); end
    tick();
    checks++; if (host_if.dout !== 8'hFF) begin errors++; $display("FAIL basic_pop2: got %h expected ff", host_if.dout); end
    tick();
    host_if.dout_ready = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL basic_drained_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_drained_empty: got %b expected 1", empty); end
    checks++; if (host_if.dout_valid !== 1'b0) begin errors++; $display("FAIL basic_drained_valid: got %b expected 0", host_if.dout_valid); end
    checks++; if (host_if.dout !== 8'h00) begin errors++; $display("FAIL basic_drained_dout: got %h expected 00", host_if.dout); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 2);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before_drop: got %b expected 0", overflow); end
    send_byte(8'h10, 2);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    // Another drop coinciding with clear: set has priority
    rx_done = 1'b1;
    rx_data = 8'h11;
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_priority: got %b expected 1", overflow); end
    rx_done = 1'b0;
    tick();
    host_if.dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (host_if.dout !== 8'(i)) begin errors++; $display("FAIL ovf_pop%0d: got %h expected %h", i, host_if.dout, 8'(i)); end
      tick();
    end
    host_if.dout_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %b expected 1", empty); end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 2);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fpp_full: got %b expected 1", full); end
    rx_done = 1'b1;
    rx_data = 8'hEE;
    host_if.dout_ready = 1'b1;
    tick();
    host_if.dout_ready = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fpp_count: got %0d expected 16", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %b expected 0", overflow); end
    repeat (3) tick();
    rx_done = 1'b0;
    tick();
    host_if.dout_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      checks++; if (host_if.dout !== 8'h20 + 8'(i)) begin errors++; $display("FAIL fpp_pop%0d: got %h expected %h", i, host_if.dout, 8'h20 + 8'(i)); end
      tick();
    end
    checks++; if (host_if.dout !== 8'hEE) begin errors++; $display("FAIL fpp_last: got %h expected ee", host_if.dout); end
    tick();
    host_if.dout_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fpp_drained: got %b expected 1", empty); end
  endtask

  task automatic test_reset_levels();
    send_byte(8'h55, 2);
    send_byte(8'h66, 2);
    // Reset mid-operation with done and err already high
    rx_done = 1'b1;
    rx_err = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_done_high_count: got %0d expected 0", count); end
    checks++; if (host_if.dout_valid !== 1'b0) begin errors++; $display("FAIL rst_done_high_valid: got %b expected 0", host_if.dout_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_err_high: got %b expected 0", frame_err); end
    rx_done = 1'b0;
    rx_err = 1'b0;
    tick();
  endtask

  task automatic test_frame_err();
    send_byte(8'h77, 2);
    rx_err = 1'b1;
    tick();
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_pulse: got %b expected 1", frame_err); end
`ifdef UART_RX_FIFO_ERR_COUNT_EN
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL ferr_count1: got %0d expected 1", err_count); end
`endif
    tick();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_one_clk: got %b expected 0", frame_err); end
    repeat (4) tick();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_level_held: got %b expected 0", frame_err); end
    rx_err = 1'b0;
    tick();
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL ferr_queue_count: got %0d expected 1", count); end
    checks++; if (host_if.dout !== 8'h77) begin errors++; $display("FAIL ferr_queue_data: got %h expected 77", host_if.dout); end
`ifdef UART_RX_FIFO_ERR_COUNT_EN
    for (int i = 0; i < 300; i++) begin
      rx_err = 1'b1; tick();
      rx_err = 1'b0; tick();
    end
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL ferr_count_sat: got %h expected ff", err_count); end
    // Clear coinciding with a new edge leaves exactly one
    rx_err = 1'b1;
    clear_err_count = 1'b1;
    tick();
    clear_err_count = 1'b0;
    rx_err = 1'b0;
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL ferr_clear_inc: got %0d expected 1", err_count); end
    clear_err_count = 1'b1;
    tick();
    clear_err_count = 1'b0;
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL ferr_clear: got %0d expected 0", err_count); end
`endif
    host_if.dout_ready = 1'b1;
    tick();
    host_if.dout_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ferr_drain: got %b expected 1", empty); end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    send_byte(8'h80, 1);
    for (int i = 0; i < 40; i++) begin
      v = 8'h81 + 8'(i);
      rx_done = 1'b1;
      rx_data = v;
      host_if.dout_ready = 1'b1;
      tick();
      host_if.dout_ready = 1'b0;
      rx_done = 1'b0;
      checks++; if (host_if.dout !== v) begin errors++; $display("FAIL wrap_data%0d: got %h expected %h", i, host_if.dout, v); end
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL wrap_count%0d: got %0d expected 1", i, count); end
      tick();
    end
    host_if.dout_ready = 1'b1;
    tick();
    host_if.dout_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_drain: got %b expected 1", empty); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_reset_levels();
    test_frame_err();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Byte buffer directly downstream of the 8-bit UART receiver, clocked by the same 16x-oversample rx clock.
- Captures each received byte on the rising edge of the receiver's `done` pulse (held 16 ticks) and queues it.
- Presents bytes to the host side through a first-word-fall-through valid/ready interface.
- Flags overflow and tracks framing errors reported by the receiver.

Parameters:
- DEPTH, 16, number of byte entries; power of two, >= 2.
- ADDR_WIDTH, 4, log2(DEPTH); must be consistent with DEPTH.

Ports:
- clk  input  1  rx sampling clock (16x baud), same clock as the receiver
- rst_n  input  1  synchronous active-low reset
- rx_done  input  1  receiver done; high for one baud interval per good byte
- rx_err  input  1  receiver err level
- rx_data  input  8  receiver output data; valid while rx_done high
- dout  output  8  head-of-queue byte
- dout_valid  output  1  dout holds a valid byte
- dout_ready  input  1  consumer accepts dout this cycle
- count  output  ADDR_WIDTH+1  number of bytes stored, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  sticky; a byte was dropped because the buffer was full
- clear_overflow  input  1  clears overflow
- frame_err  output  1  one-clk pulse on each rising edge of rx_err

Behaviour:
- Reset (rst_n low at posedge clk):
  - Pointers and count become 0; empty=1, full=0; dout=0, dout_valid=0; overflow=0, frame_err=0.
  - Edge-detect history registers for rx_done and rx_err are set to 1. A `done` or `err` already high when reset releases is not captured.
  - Reset mid-operation discards all stored bytes.
- Push:
  - push = rx_done & ~done_q, where done_q is rx_done delayed one clk.
  - rx_data is sampled in the same cycle push is high.
  - Exactly one push per done pulse, regardless of pulse length.
- Pop: pop = dout_valid & dout_ready.
- Output path:
  - dout_valid = ~empty. dout = memory[rd_ptr] when not empty, else 8'h00.
  - Latency from the push cycle to dout_valid high is 1 clk.
- Pointers:
  - rd_ptr and wr_ptr are ADDR_WIDTH bits and wrap modulo DEPTH.
  - count is updated +1 on push only, -1 on pop only, and held on both or neither.
- Boundary cases:
  - Full, push, no pop: byte dropped; overflow set next clk; count, pointers and memory unchanged.
  - Full, push and pop in the same cycle: push accepted, count stays DEPTH, no overflow.
  - Empty, pop is impossible (dout_valid=0); dout_ready is ignored.
  - count == 1, push and pop in the same cycle: count stays 1; dout shows the new byte next clk.
- overflow:
  - Cleared by clear_overflow.
  - Set takes priority over clear when both occur in the same cycle.
- frame_err:
  - Pulse = rx_err & ~err_q, registered; high one clk.
  - Does not affect queue contents.
- No state machine beyond pointer/count logic. All outputs are registered except dout/dout_valid, which are decoded from registered state.

Optional Feature:
- Macro: UART_RX_FIFO_ERR_COUNT_EN.
- Defined:
  - Adds output err_count [7:0], the number of frame_err pulses, saturating at 8'hFF.
  - Adds input clear_err_count, which zeroes err_count.
  - An increment in the same cycle as clear_err_count yields 1.
  - err_count is reset to 0 by rst_n.
- Not defined: neither port exists; frame_err behaviour is unchanged.

Test Plan:
- Reset, then 3 done pulses (16 clks high each) with rx_data 8'hA5, 8'h3C, 8'hFF, dout_ready=0 -> count=3; dout=8'hA5 with dout_valid=1 starting 1 clk after the first push.
- Then dout_ready=1 for 3 clks -> dout sequence A5, 3C, FF; count=0, empty=1, dout_valid=0, dout=8'h00.
- DEPTH=16: push 17 bytes 8'h00..8'h10, no pops -> full=1, count=16, overflow=1; pops return 00..0F (0x10 dropped); clear_overflow -> overflow=0.
- Full buffer, done rising edge coincident with dout_ready=1 -> count stays 16, overflow stays 0, new byte returned last.
- rx_done held high across rst_n deassertion -> no push, count=0. Later, rx_err rises -> frame_err high for exactly 1 clk. With UART_RX_FIFO_ERR_COUNT_EN defined, err_count=1, and 300 err edges -> err_count=8'hFF.
- Pointer wrap: 40 push/pop pairs at count == 1 -> data order preserved; count never exceeds 2.
